i2c_frame_fifo: RTL and testbench

- Parametrised successor to the single-frame bit-serial FIFO on the I2C datapath.
- Deserialises address/data bits into FRAME_W-bit frames and stores up to DEPTH frames in a circular buffer.
- Re-serialises stored frames MSB-first on request.
- Adds real full/empty tracking, an occupancy count, overflow/underflow pulses, write abort and independent concurrent write/read engines.

---
 rtl/i2c_frame_fifo.sv | 88 ++++++++
 tb/tb_i2c_frame_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_fifo.sv
// i2c_frame_fifo: bit-serial frame FIFO that assembles FRAME_W-bit frames MSB-first, stores up to DEPTH of them and replays them MSB-first.
// Ports: clk, rst (sync, active high); addr_data/wr_en/wr_abort feed the write engine;
// rd_en pops a frame onto data_out/data_valid (rd_busy while shifting);
// empty/full/count report committed frames; overflow/underflow pulse one cycle after a refused start.
module i2c_frame_fifo #(
   parameter int FRAME_W = 15,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             addr_data,
   input  logic             wr_en,
   input  logic             wr_abort,
   input  logic             rd_en,
   output logic             data_out,
   output logic             data_valid,
   output logic             rd_busy,
   output logic             empty,
   output logic             full,
   output logic [PTR_W:0]   count,
   output logic             overflow,
   output logic             underflow
);
   localparam int CW = $clog2(FRAME_W);
   localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);
   typedef enum logic {W_IDLE, W_SHIFT} w_state_t;
   typedef enum logic {R_IDLE, R_SHIFT} r_state_t;
   w_state_t w_state, w_next;
   r_state_t r_state, r_next;
   logic [FRAME_W-1:0] mem [DEPTH];
   logic [FRAME_W-1:0] wr_sr, rd_sr;
   logic [CW-1:0] wr_cnt, rd_cnt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic wr_take, commit, wr_refuse, rd_last, rd_ready, pop, rd_refuse;
   assign empty = count == '0;
   assign full = count == (PTR_W+1)'(DEPTH);
   assign data_valid = r_state == R_SHIFT;
   assign rd_busy = data_valid;
   assign data_out = data_valid & rd_sr[FRAME_W-1];
   // Fullness is only checked at frame start; an assembling frame owns its slot since reads only free space.
   always_comb begin
      wr_refuse = w_state == W_IDLE && wr_en && full;
      wr_take = wr_en && (w_state == W_SHIFT ? !wr_abort : !full);
      commit = w_state == W_SHIFT && wr_take && wr_cnt == LAST;
      w_next = w_state == W_IDLE ? (wr_take ? W_SHIFT : W_IDLE)
                                 : ((wr_abort || commit) ? W_IDLE : W_SHIFT);
      // The edge ending the last bit may already accept the next pop, so frames can run back to back.
      rd_last = r_state == R_SHIFT && rd_cnt == LAST;
      rd_ready = r_state == R_IDLE || rd_last;
      pop = rd_ready && rd_en && !empty;
      rd_refuse = rd_ready && rd_en && empty;
      r_next = pop ? R_SHIFT : (rd_last ? R_IDLE : r_state);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_cnt <= (commit || (w_state == W_SHIFT && wr_abort)) ? '0 : (wr_take ? wr_cnt + 1'b1 : wr_cnt);
         rd_cnt <= pop ? '0 : (r_state == R_SHIFT ? rd_cnt + 1'b1 : rd_cnt);
         wr_ptr <= commit ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count <= (commit && !pop) ? count + 1'b1 : ((pop && !commit) ? count - 1'b1 : count);
         overflow <= wr_refuse;
         underflow <= rd_refuse;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_take) wr_sr <= {wr_sr[FRAME_W-2:0], addr_data};
      if (commit) mem[wr_ptr] <= {wr_sr[FRAME_W-2:0], addr_data};
      rd_sr <= pop ? mem[rd_ptr] : {rd_sr[FRAME_W-2:0], 1'b0};
   end
endmodule

// File: tb/tb_i2c_frame_fifo.sv
// tb_i2c_frame_fifo: scoreboard bench for i2c_frame_fifo with FRAME_W=15, DEPTH=4.
module tb_i2c_frame_fifo;
   logic clk = 1'b0, rst = 1'b1, addr_data = 1'b0, wr_en = 1'b0, wr_abort = 1'b0, rd_en = 1'b0;
   logic data_out, data_valid, rd_busy, empty, full, overflow, underflow;
   logic [2:0] count;
   int checks = 0, failures = 0;
   int run_len = 0, max_run = 0;
   logic exp_q[$];
   logic [14:0] model_q[$];
   logic [14:0] fr;

   i2c_frame_fifo #(.FRAME_W(15), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .addr_data(addr_data), .wr_en(wr_en), .wr_abort(wr_abort),
      .rd_en(rd_en), .data_out(data_out), .data_valid(data_valid), .rd_busy(rd_busy),
      .empty(empty), .full(full), .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_bits(input logic [14:0] f, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         addr_data = f[i];
         wr_en = 1'b1;
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic write_frame(input logic [14:0] f);
      write_bits(f, 14, 0);
      model_q.push_back(f);
   endtask

   task automatic push_exp;
      logic [14:0] f;
      f = model_q.pop_front();
      for (int i = 14; i >= 0; i--) exp_q.push_back(f[i]);
   endtask

   task automatic read_frame;
      push_exp();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      repeat (14) tick();
   endtask

   always @(negedge clk) begin
      if (rst) run_len = 0;
      else if (data_valid) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (exp_q.size() == 0) check("unexpected_bit", 1, 0);
         else check("data_out", data_out, exp_q.pop_front());
      end else begin
         run_len = 0;
         check("data_out_idle", data_out, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) tick();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_valid", data_valid, 0);
      check("rst_busy", rd_busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_udf", underflow, 0);
      rst = 1'b0;
      tick();
      // single frame round trip
      write_frame(15'h5A3C);
      check("t1_count", count, 1);
      check("t1_empty", empty, 0);
      push_exp();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t1_busy", rd_busy, 1);
      check("t1_count_pop", count, 0);
      check("t1_empty_pop", empty, 1);
      repeat (14) tick();
      check("t1_last_valid", data_valid, 1);
      tick();
      check("t1_valid_end", data_valid, 0);
      check("t1_busy_end", rd_busy, 0);
      // fill, overflow, back-to-back drain
      write_frame(15'h0001);
      write_frame(15'h4000);
      write_frame(15'h7FFF);
      write_frame(15'h2AAA);
      check("t2_full", full, 1);
      check("t2_count", count, 4);
      addr_data = 1'b1;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      check("t2_ovf", overflow, 1);
      check("t2_count_ovf", count, 4);
      tick();
      check("t2_ovf_end", overflow, 0);
      max_run = 0;
      repeat (4) read_frame();
      tick();
      check("t2_run", max_run, 60);
      check("t2_empty", empty, 1);
      check("t2_full_end", full, 0);
      // abort mid-frame, abort wins over wr_en
      write_bits(15'h7F00, 14, 8);
      check("t3_count_part", count, 0);
      wr_abort = 1'b1;
      wr_en = 1'b1;
      addr_data = 1'b1;
      tick();
      wr_abort = 1'b0;
      wr_en = 1'b0;
      check("t3_count_abort", count, 0);
      write_frame(15'h1234);
      check("t3_count", count, 1);
      read_frame();
      tick();
      check("t3_count_end", count, 0);
      // stall mid-frame
      fr = 15'h6B5D;
      write_bits(fr, 14, 8);
      addr_data = 1'b1;
      repeat (5) tick();
      check("t4_count_stall", count, 0);
      write_bits(fr, 7, 0);
      model_q.push_back(fr);
      check("t4_count", count, 1);
      read_frame();
      tick();
      // underflow
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t5_udf", underflow, 1);
      check("t5_valid", data_valid, 0);
      tick();
      check("t5_udf_end", underflow, 0);
      check("t5_valid_end", data_valid, 0);
      // commit and pop on the same edge
      write_frame(15'h0F0F);
      write_frame(15'h3333);
      check("t6_count", count, 2);
      fr = 15'h5555;
      write_bits(fr, 14, 1);
      addr_data = fr[0];
      wr_en = 1'b1;
      rd_en = 1'b1;
      push_exp();
      model_q.push_back(fr);
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      check("t6_count_same", count, 2);
      repeat (14) tick();
      read_frame();
      read_frame();
      tick();
      check("t6_count_end", count, 0);
      // reset during read bit 6 with a write in progress
      write_frame(15'h2D2D);
      push_exp();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      write_bits(15'h7777, 14, 9);
      rst = 1'b1;
      wr_en = 1'b1;
      rd_en = 1'b1;
      tick();
      exp_q.delete();
      model_q.delete();
      check("t7_count", count, 0);
      check("t7_empty", empty, 1);
      check("t7_full", full, 0);
      check("t7_valid", data_valid, 0);
      check("t7_busy", rd_busy, 0);
      check("t7_dout", data_out, 0);
      check("t7_ovf", overflow, 0);
      check("t7_udf", underflow, 0);
      rst = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      tick();
      write_frame(15'h4ABC);
      check("t7_count_rt", count, 1);
      read_frame();
      tick();
      check("t7_count_end", count, 0);
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
      check("drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
